// File: rtl/mc_controlunit.sv
// Multi-cycle control unit for a small RV32I subset (addi/add/sub/lw/sw/beq/bne).
// Runs FETCH -> DECODE -> EXEC -> (MEM) -> (WB). A per-state wait counter
// bounds how long memory may stall. Illegal encodings and memory timeouts
// park the unit in TRAP with a sticky flag that only reset clears.
module mc_controlunit #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             EQ,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             PCsrc,
  output logic             RegWrite,
  output logic [2:0]       ALUctrl,
  output logic             ALUsrc,
  output logic [1:0]       ImmSrc,
  output logic             ResultSrc,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_count
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef struct packed {
    logic addi;
    logic add;
    logic sub;
    logic lw;
    logic sw;
    logic beq;
    logic bne;
  } dec_t;

  state_t              state, next;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                run;       // low from reset until the first clock edge
  logic                set_ill, set_bus;
  logic                timeout_hit;
  dec_t                dec;
  logic                legal;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_instr_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  // Register and immediate fields belong to the datapath, not the control unit.
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  // Instruction decode; anything not matched exactly is illegal.
  always_comb begin
    dec      = '0;
    dec.addi = (opcode == 7'h13) && (funct3 == 3'b000);
    dec.add  = (opcode == 7'h33) && (funct3 == 3'b000) && (funct7 == 7'h00);
    dec.sub  = (opcode == 7'h33) && (funct3 == 3'b000) && (funct7 == 7'h20);
    dec.lw   = (opcode == 7'h03) && (funct3 == 3'b010);
    dec.sw   = (opcode == 7'h23) && (funct3 == 3'b010);
    dec.beq  = (opcode == 7'h63) && (funct3 == 3'b000);
    dec.bne  = (opcode == 7'h63) && (funct3 == 3'b001);
  end

  assign legal = |dec;

  // Last allowed stall cycle: the count including this cycle equals TIMEOUT.
  assign timeout_hit = (wait_cnt == WAIT_W'(TIMEOUT - 1));

  // Next-state and Moore output decode (PCsrc also looks at EQ).
  always_comb begin
    next      = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    PCsrc     = 1'b0;
    RegWrite  = 1'b0;
    ALUctrl   = 3'b000;
    ALUsrc    = 1'b0;
    ImmSrc    = 2'b00;
    ResultSrc = 1'b0;
    set_ill   = 1'b0;
    set_bus   = 1'b0;
    case (state)
      FETCH: begin
        if (run) begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we = 1'b1;
            next  = DECODE;
          end else if (timeout_hit) begin
            next    = TRAP;
            set_bus = 1'b1;
          end
        end
      end
      DECODE: begin
        next    = legal ? EXEC : TRAP;
        set_ill = !legal;
      end
      EXEC: begin
        if (dec.addi) begin
          ALUsrc = 1'b1;
          next   = WB;
        end else if (dec.add || dec.sub) begin
          ALUctrl = dec.sub ? 3'b001 : 3'b000;
          next    = WB;
        end else if (dec.lw || dec.sw) begin
          ALUsrc = 1'b1;
          ImmSrc = dec.sw ? 2'b01 : 2'b00;
          next   = MEM;
        end else if (dec.beq || dec.bne) begin
          ALUctrl = 3'b001;
          ImmSrc  = 2'b10;
          pc_we   = 1'b1;
          PCsrc   = dec.beq ? EQ : !EQ;
          next    = FETCH;
        end else begin
          // instr is held stable from DECODE, so this is unreachable
          next = TRAP;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = dec.sw;
        if (mem_ready) begin
          if (dec.sw) begin
            pc_we = 1'b1;
            next  = FETCH;
          end else begin
            next = WB;
          end
        end else if (timeout_hit) begin
          next    = TRAP;
          set_bus = 1'b1;
        end
      end
      WB: begin
        RegWrite  = 1'b1;
        pc_we     = 1'b1;
        ResultSrc = dec.lw;
        next      = FETCH;
      end
      TRAP: next = TRAP;
      default: next = FETCH;
    endcase
  end

  // State register plus the one-shot run flag that holds off mem_req in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      run   <= 1'b0;
    end else begin
      state <= next;
      run   <= 1'b1;
    end
  end

  // Stall counter: clears on every state change, counts memory stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (next != state) begin
      wait_cnt <= '0;
    end else if (((state == FETCH) && run || (state == MEM)) && !mem_ready) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Sticky trap flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      if (set_ill) illegal <= 1'b1;
      if (set_bus) bus_err <= 1'b1;
    end
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     instr_count <= '0;
    else if (pc_we) instr_count <= instr_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_mc_controlunit.sv
// Scoreboard bench for mc_controlunit: each directed test pushes the expected
// per-cycle output records, a negedge monitor pops and compares every cycle
// in which the DUT drives any control output.
module tb_mc_controlunit;

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_LW   = 32'h0080A283;
  localparam logic [31:0] I_SW   = 32'h0050A423;
  localparam logic [31:0] I_BEQ  = 32'h00208063;
  localparam logic [31:0] I_BNE  = 32'h00209063;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        EQ = 1'b0;
  logic        mem_ready = 1'b0;

  logic        mem_req, mem_we, ir_we, pc_we, PCsrc, RegWrite, ALUsrc, ResultSrc, illegal, bus_err;
  logic [2:0]  ALUctrl;
  logic [1:0]  ImmSrc;
  logic [15:0] instr_count;

  logic        m4_req, m4_we, i4_we, p4_we, p4_src, r4_w, a4_src, r4_src, ill4, berr4;
  logic [2:0]  a4_ctrl;
  logic [1:0]  imm4;
  logic [3:0]  cnt4;

  mc_controlunit #(.CNT_W(16), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .EQ(EQ), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we), .PCsrc(PCsrc),
    .RegWrite(RegWrite), .ALUctrl(ALUctrl), .ALUsrc(ALUsrc), .ImmSrc(ImmSrc),
    .ResultSrc(ResultSrc), .illegal(illegal), .bus_err(bus_err), .instr_count(instr_count)
  );

  mc_controlunit #(.CNT_W(4), .TIMEOUT(15)) dut4 (
    .clk(clk), .rst_n(rst_n), .instr(instr), .EQ(EQ), .mem_ready(mem_ready),
    .mem_req(m4_req), .mem_we(m4_we), .ir_we(i4_we), .pc_we(p4_we), .PCsrc(p4_src),
    .RegWrite(r4_w), .ALUctrl(a4_ctrl), .ALUsrc(a4_src), .ImmSrc(imm4),
    .ResultSrc(r4_src), .illegal(ill4), .bus_err(berr4), .instr_count(cnt4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int          cyc;
    logic        ir, pcw, pcs, rw, mr, mw, rs;
    logic [2:0]  alu;
    logic        asrc;
    logic [1:0]  imm;
    logic [15:0] cnt;
  } ev_t;

  ev_t q[$];
  int  n_chk = 0;
  int  n_pass = 0;
  int  base = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Expected record for cycle n (1 = first cycle after reset release).
  task automatic push(input int n, input logic ir, pcw, pcs, rw, mr, mw, rs,
                      input logic [2:0] alu, input logic asrc, input logic [1:0] imm,
                      input logic [15:0] cnt);
    ev_t e;
    e = '{base + n - 1, ir, pcw, pcs, rw, mr, mw, rs, alu, asrc, imm, cnt};
    q.push_back(e);
  endtask

  task automatic p_fetch(input int n, input logic [15:0] cnt);
    push(n, 1, 0, 0, 0, 1, 0, 0, 3'd0, 0, 2'd0, cnt);
  endtask
  task automatic p_wait(input int n, input logic [15:0] cnt);
    push(n, 0, 0, 0, 0, 1, 0, 0, 3'd0, 0, 2'd0, cnt);
  endtask
  task automatic p_wb(input int n, input logic rs, input logic [15:0] cnt);
    push(n, 0, 1, 0, 1, 0, 0, rs, 3'd0, 0, 2'd0, cnt);
  endtask

  // Monitor: any active control output is an observable event.
  always @(negedge clk) begin
    ev_t a, e;
    if (mem_req | mem_we | ir_we | pc_we | PCsrc | RegWrite | ResultSrc | ALUsrc |
        (|ALUctrl) | (|ImmSrc)) begin
      a = '{cyc, ir_we, pc_we, PCsrc, RegWrite, mem_req, mem_we, ResultSrc,
            ALUctrl, ALUsrc, ImmSrc, instr_count};
      if (q.size() == 0) begin
        chk($sformatf("unexpected event n=%0d", cyc - base + 1), 64'(a), 64'(0));
      end else begin
        e = q.pop_front();
        chk($sformatf("event n=%0d", e.cyc - base + 1), 64'(a), 64'(e));
      end
    end
  end

  // Drive mem_ready per cycle; bit n of nr set means not ready in cycle n.
  task automatic run(input int ncyc, input logic [63:0] nr);
    for (int n = 1; n <= ncyc; n++) begin
      mem_ready = (n < 64) ? !nr[n] : 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  // Async reset mid-cycle, check everything is quiet, release before a rising edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset outputs",
        64'({mem_req, mem_we, ir_we, pc_we, PCsrc, RegWrite, ALUctrl, ALUsrc, ImmSrc,
             ResultSrc, illegal, bus_err, instr_count}), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    base = cyc;
  endtask

  initial begin
    #2;
    do_reset();

    // addi: fetch, decode, exec (imm), writeback
    instr = I_ADDI; EQ = 0;
    p_fetch(1, 0); push(3, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 2'd0, 0); p_wb(4, 0, 0);
    run(4, 0);
    chk("addi instr_count", 64'(instr_count), 64'(1));
    do_reset();

    // add: EXEC is all-zero
    instr = I_ADD;
    p_fetch(1, 0); p_wb(4, 0, 0);
    run(4, 0);
    do_reset();

    // sub
    instr = I_SUB;
    p_fetch(1, 0); push(3, 0, 0, 0, 0, 0, 0, 0, 3'd1, 0, 2'd0, 0); p_wb(4, 0, 0);
    run(4, 0);
    do_reset();

    // branches: {instr, EQ, expected PCsrc}
    for (int t = 0; t < 4; t++) begin
      logic [31:0] bi;
      logic        beq_v, pcs_v;
      bi    = (t < 2) ? I_BNE : I_BEQ;
      beq_v = t[0];
      pcs_v = (t < 2) ? (t == 0) : (t == 3);
      instr = bi; EQ = beq_v;
      p_fetch(1, 0); push(3, 0, 1, pcs_v, 0, 0, 0, 0, 3'd1, 0, 2'd2, 0);
      run(3, 0);
      chk("branch instr_count", 64'(instr_count), 64'(1));
      do_reset();
    end
    EQ = 0;

    // lw with data ready delayed by 3 cycles
    instr = I_LW;
    p_fetch(1, 0); push(3, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 2'd0, 0);
    for (int n = 4; n <= 7; n++) p_wait(n, 0);
    p_wb(8, 1, 0);
    run(8, 64'h70);
    do_reset();

    // sw: write strobe with request, retire on ready
    instr = I_SW;
    p_fetch(1, 0); push(3, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 2'd1, 0);
    push(4, 0, 1, 0, 0, 1, 1, 0, 3'd0, 0, 2'd0, 0);
    run(4, 0);
    do_reset();

    // fetch timeout: 15 stall cycles, then TRAP and quiet
    instr = I_ADDI;
    for (int n = 1; n <= 15; n++) p_wait(n, 0);
    run(17, 64'hFFFE);
    chk("timeout flags {illegal,bus_err}", 64'({illegal, bus_err}), 64'(2'b01));
    do_reset();

    // ready arrives on exactly the 15th cycle: no error
    for (int n = 1; n <= 14; n++) p_wait(n, 0);
    p_fetch(15, 0); push(17, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 2'd0, 0); p_wb(18, 0, 0);
    run(18, 64'h7FFE);
    chk("boundary flags {illegal,bus_err}", 64'({illegal, bus_err}), 64'(2'b00));
    do_reset();

    // illegal opcode: decode then TRAP, no further requests
    instr = 32'h0;
    p_fetch(1, 0);
    run(8, 0);
    chk("illegal flags {illegal,bus_err}", 64'({illegal, bus_err}), 64'(2'b10));
    do_reset();
    chk("flags after reset", 64'({illegal, bus_err}), 64'(2'b00));
    instr = I_ADDI;
    p_fetch(1, 0); push(3, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 2'd0, 0); p_wb(4, 0, 0);
    run(4, 0);
    do_reset();

    // reset in the middle of a stalled lw MEM phase, then fetch resumes
    instr = I_LW;
    p_fetch(1, 0); push(3, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 2'd0, 0);
    p_wait(4, 0); p_wait(5, 0);
    run(5, 64'h7F0);
    do_reset();
    instr = I_ADDI;
    p_fetch(1, 0); push(3, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 2'd0, 0); p_wb(4, 0, 0);
    run(4, 0);
    do_reset();

    // 17 back-to-back addi: 16-bit counter reaches 17, 4-bit counter wraps to 1
    instr = I_ADDI;
    for (int k = 0; k < 17; k++) begin
      p_fetch(4*k + 1, 16'(k));
      push(4*k + 3, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 2'd0, 16'(k));
      p_wb(4*k + 4, 0, 16'(k));
    end
    run(68, 0);
    chk("count16 after 17", 64'(instr_count), 64'(17));
    chk("count4 wrap", 64'(cnt4), 64'(1));
    do_reset();

    chk("scoreboard drained", 64'(q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
